// File: rtl/aes_top.sv
`default_nettype none
// ============================================================================
//  Module   : aes_top
//  Purpose  : Iterative AES-128 encryption core. One AES round per clock,
//             with round keys expanded on the fly. A stored cipher key can
//             be loaded, or a per-command key can be supplied with the block.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1    rising-edge clock
//    rst_n         in   1    asynchronous active-low reset
//    input_valid   in   1    command on opcode/data_in is valid
//    opcode        in   5    0 LOAD_KEY, 1 ENCRYPT, 2 ENCRYPT_KEY, 3 ZEROIZE*
//    data_in       in   256  [255:128] key field, [127:0] key or plaintext
//    input_ready   out  1    core idle, command will be accepted
//    output_ready  in   1    consumer takes data_out
//    output_valid  out  1    data_out holds a finished ciphertext
//    data_out      out  128  ciphertext (FIPS-197 order, [127:120] = byte 0)
//    busy          out  1    command in progress or result pending
//  Configuration
//    AES_ZEROIZE_EN  when defined, opcode 3 clears the stored key and
//                    data_out; otherwise opcode 3 is a no-op command.
// ============================================================================
module aes_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         input_valid,
    input  logic [4:0]   opcode,
    input  logic [255:0] data_in,
    output logic         input_ready,
    input  logic         output_ready,
    output logic         output_valid,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam logic [4:0] OP_LOAD_KEY    = 5'd0;
    localparam logic [4:0] OP_ENCRYPT     = 5'd1;
    localparam logic [4:0] OP_ENCRYPT_KEY = 5'd2;
`ifdef AES_ZEROIZE_EN
    localparam logic [4:0] OP_ZEROIZE     = 5'd3;
`endif
    localparam logic [3:0] LAST_ROUND     = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEYLD = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [127:0]   key_q;      // stored cipher key
    logic [127:0]   blk_q;      // working AES state
    logic [127:0]   rk_q;       // round key used by the previous round
    logic [3:0]     round_q;
    logic [127:0]   dout_q;
    logic           valid_q;
    logic           ready_q;
    logic           busy_q;

    logic [127:0]   rk_d;
    logic [127:0]   blk_d;
    logic [127:0]   sr_w;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // Round transformations; byte i lives at [127-8i -: 8], column-major
    // ------------------------------------------------------------------
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c    -: 8];
            a1 = s[127-32*c-8  -: 8];
            a2 = s[127-32*c-16 -: 8];
            a3 = s[127-32*c-24 -: 8];
            o[127-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next round key from the current one (one step of the key schedule).
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        rk_d  = key_step(rk_q, rcon(round_q));
        sr_w  = shift_rows(sub_bytes(blk_q));
        blk_d = ((round_q == LAST_ROUND) ? sr_w : mix_columns(sr_w)) ^ rk_d;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake/status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            blk_q   <= '0;
            rk_q    <= '0;
            round_q <= 4'd0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (input_valid) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        case (opcode)
                            OP_LOAD_KEY: begin
                                key_q   <= data_in[127:0];
                                state_q <= KEYLD;
                            end
                            OP_ENCRYPT: begin
                                blk_q   <= data_in[127:0] ^ key_q;
                                rk_q    <= key_q;
                                round_q <= 4'd1;
                                state_q <= ROUND;
                            end
                            OP_ENCRYPT_KEY: begin
                                blk_q   <= data_in[127:0] ^ data_in[255:128];
                                rk_q    <= data_in[255:128];
                                round_q <= 4'd1;
                                state_q <= ROUND;
                            end
`ifdef AES_ZEROIZE_EN
                            OP_ZEROIZE: begin
                                key_q   <= '0;
                                dout_q  <= '0;
                                state_q <= KEYLD;
                            end
`endif
                            default: state_q <= KEYLD;  // accepted, no effect
                        endcase
                    end
                end
                KEYLD: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                ROUND: begin
                    blk_q <= blk_d;
                    rk_q  <= rk_d;
                    if (round_q == LAST_ROUND) begin
                        dout_q  <= blk_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (output_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign input_ready  = ready_q;
    assign output_valid = valid_q;
    assign data_out     = dout_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_top
//  Purpose  : Directed self-checking bench for aes_top: reset state, key
//             load, encrypt with stored and supplied keys, latency, output
//             hold/backpressure, back-to-back commands, unsupported opcodes
//             and reset abort. FIPS-197 vectors are constants; the key=1
//             case uses a bytewise reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_top;

    logic         clk;
    logic         rst_n;
    logic         input_valid;
    logic [4:0]   opcode;
    logic [255:0] data_in;
    logic         input_ready;
    logic         output_ready;
    logic         output_valid;
    logic [127:0] data_out;
    logic         busy;

    int n_checks;
    int n_fail;

    localparam logic [127:0] C_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [7:0] sbox_tab [0:255];

    aes_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_valid  (input_valid),
        .opcode       (opcode),
        .data_in      (data_in),
        .input_ready  (input_ready),
        .output_ready (output_ready),
        .output_valid (output_valid),
        .data_out     (data_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = m_xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from a brute-force inverse search plus the bitwise affine map.
    task automatic build_sbox;
        logic [7:0] inv, s;
        logic [7:0] cc;
        cc = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ cc[i];
            sbox_tab[a] = s;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] kw [0:175];
        logic [7:0] st [0:15];
        logic [7:0] tmp [0:15];
        logic [7:0] t [0:3];
        logic [7:0] t0, rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int j = 0; j < 16; j++) kw[j] = key[127-8*j -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = kw[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = t[0];
                t[0] = sbox_tab[t[1]] ^ rc;
                t[1] = sbox_tab[t[2]];
                t[2] = sbox_tab[t[3]];
                t[3] = sbox_tab[t0];
                rc = m_xt(rc);
            end
            for (int j = 0; j < 4; j++) kw[4*i+j] = kw[4*(i-4)+j] ^ t[j];
        end
        for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8] ^ kw[j];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++) tmp[j] = sbox_tab[st[j]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = m_mul(a0,2) ^ m_mul(a1,3) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ m_mul(a1,2) ^ m_mul(a2,3) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ m_mul(a2,2) ^ m_mul(a3,3);
                    st[4*c+3] = m_mul(a0,3) ^ a1 ^ a2 ^ m_mul(a3,2);
                end
            end
            for (int j = 0; j < 16; j++) st[j] = st[j] ^ kw[16*rnd+j];
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge (the acceptance edge), then scramble inputs.
    task automatic send(input logic [4:0] op, input logic [255:0] d);
        input_valid = 1'b1;
        opcode      = op;
        data_in     = d;
        tick;
        input_valid = 1'b0;
        opcode      = 5'h1f;
        data_in     = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
    endtask

    // Edges elapsed since acceptance until output_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!output_valid && lat < 30) begin
            tick;
            lat++;
        end
    endtask

    task automatic do_encrypt(input logic [4:0] op, input logic [255:0] d,
                              output int lat, output logic [127:0] res);
        send(op, d);
        wait_valid(lat);
        res = data_out;
        output_ready = 1'b1;
        tick;
        output_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
        opcode = '0; data_in = '0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (input_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", input_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", output_valid); end
        n_checks++;
        if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", data_out); end
    endtask

    task automatic test_encrypt_zero_key;
        int lat;
        send(5'd1, 256'h0);
        n_checks++;
        if ({busy, input_ready} !== 2'b10) begin n_fail++; $display("FAIL enc0_busy_ready: got %b expected 10", {busy, input_ready}); end
        wait_valid(lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL enc0_latency: got %0d expected 10", lat); end
        n_checks++;
        if (data_out !== C_ZERO_CT) begin n_fail++; $display("FAIL enc0_data: got %h expected %h", data_out, C_ZERO_CT); end
        output_ready = 1'b1;
        tick;
        output_ready = 1'b0;
        n_checks++;
        if ({output_valid, input_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL enc0_handshake: got %b expected 010", {output_valid, input_ready, busy}); end
    endtask

    task automatic test_load_key;
        int lat;
        logic [127:0] res;
        send(5'd0, 256'd1);
        n_checks++;
        if ({busy, input_ready, output_valid} !== 3'b100) begin n_fail++; $display("FAIL loadkey_keyld: got %b expected 100", {busy, input_ready, output_valid}); end
        tick;
        n_checks++;
        if ({busy, input_ready, output_valid} !== 3'b010) begin n_fail++; $display("FAIL loadkey_idle: got %b expected 010", {busy, input_ready, output_valid}); end
        do_encrypt(5'd1, 256'h0, lat, res);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL key1_latency: got %0d expected 10", lat); end
        n_checks++;
        if (res !== ref_aes(128'd1, 128'h0)) begin n_fail++; $display("FAIL key1_data: got %h expected %h", res, ref_aes(128'd1, 128'h0)); end
    endtask

    task automatic test_encrypt_key;
        int lat;
        logic [127:0] res;
        do_encrypt(5'd2, {C_FIPS_KEY, C_FIPS_PT}, lat, res);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL fips_latency: got %0d expected 10", lat); end
        n_checks++;
        if (res !== C_FIPS_CT) begin n_fail++; $display("FAIL fips_data: got %h expected %h", res, C_FIPS_CT); end
        do_encrypt(5'd1, 256'h0, lat, res);
        n_checks++;
        if (res !== ref_aes(128'd1, 128'h0)) begin n_fail++; $display("FAIL stored_key_kept: got %h expected %h", res, ref_aes(128'd1, 128'h0)); end
    endtask

    task automatic test_hold;
        int lat;
        logic [127:0] res;
        logic [127:0] ptx;
        ptx = 128'h0123456789abcdeffedcba9876543210;
        send(5'd2, {C_FIPS_KEY, C_FIPS_PT});
        wait_valid(lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL hold_latency: got %0d expected 10", lat); end
        // a load-key attempt while not ready must be ignored
        input_valid = 1'b1; opcode = 5'd0; data_in = {128'h0, 128'hdeadbeef};
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++;
            if ({output_valid, input_ready, busy} !== 3'b101 || data_out !== C_FIPS_CT) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got v/r/b=%b data=%h expected 101 data=%h", i, {output_valid, input_ready, busy}, data_out, C_FIPS_CT);
            end
        end
        input_valid = 1'b0;
        output_ready = 1'b1;
        tick;
        output_ready = 1'b0;
        n_checks++;
        if ({output_valid, input_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL hold_release: got %b expected 010", {output_valid, input_ready, busy}); end
        n_checks++;
        if (data_out !== C_FIPS_CT) begin n_fail++; $display("FAIL hold_retain: got %h expected %h", data_out, C_FIPS_CT); end
        do_encrypt(5'd1, {128'hffff, ptx}, lat, res);
        n_checks++;
        if (res !== ref_aes(128'd1, ptx)) begin n_fail++; $display("FAIL ignored_cmd: got %h expected %h", res, ref_aes(128'd1, ptx)); end
    endtask

    task automatic test_back_to_back;
        int lat;
        output_ready = 1'b1;
        send(5'd1, 256'h0);
        wait_valid(lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 10", lat); end
        tick;
        n_checks++;
        if ({output_valid, input_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_auto_handshake: got %b expected 01", {output_valid, input_ready}); end
        send(5'd2, {C_FIPS_KEY, C_FIPS_PT});
        wait_valid(lat);
        n_checks++;
        if (lat !== 10 || data_out !== C_FIPS_CT) begin n_fail++; $display("FAIL b2b_second: got lat=%0d data=%h expected lat=10 data=%h", lat, data_out, C_FIPS_CT); end
        tick;
        output_ready = 1'b0;
    endtask

    task automatic test_unsupported;
        int lat;
        logic [127:0] res;
        send(5'd9, {C_FIPS_PT, C_FIPS_KEY});
        n_checks++;
        if ({busy, input_ready, output_valid} !== 3'b100) begin n_fail++; $display("FAIL unsup_keyld: got %b expected 100", {busy, input_ready, output_valid}); end
        tick;
        n_checks++;
        if ({busy, input_ready, output_valid} !== 3'b010 || data_out !== C_FIPS_CT) begin n_fail++; $display("FAIL unsup_noeffect: got %b data=%h expected 010 data=%h", {busy, input_ready, output_valid}, data_out, C_FIPS_CT); end
        send(5'd3, 256'h0);
        tick;
        do_encrypt(5'd1, 256'h0, lat, res);
`ifdef AES_ZEROIZE_EN
        n_checks++;
        if (res !== C_ZERO_CT) begin n_fail++; $display("FAIL zeroize_key: got %h expected %h", res, C_ZERO_CT); end
`else
        n_checks++;
        if (res !== ref_aes(128'd1, 128'h0)) begin n_fail++; $display("FAIL op3_noeffect: got %h expected %h", res, ref_aes(128'd1, 128'h0)); end
`endif
    endtask

    task automatic test_reset_mid_round;
        int lat;
        int seen;
        logic [127:0] res;
        send(5'd1, 256'h0);
        repeat (4) tick;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({input_ready, busy, output_valid} !== 3'b100 || data_out !== 128'h0) begin n_fail++; $display("FAIL abort_immediate: got r/b/v=%b data=%h expected 100 data=0", {input_ready, busy, output_valid}, data_out); end
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (output_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
        do_encrypt(5'd1, 256'h0, lat, res);
        n_checks++;
        if (res !== C_ZERO_CT) begin n_fail++; $display("FAIL abort_key0: got %h expected %h", res, C_ZERO_CT); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        build_sbox;
        test_reset;
        test_encrypt_zero_key;
        test_load_key;
        test_encrypt_key;
        test_hold;
        test_back_to_back;
        test_unsupported;
        test_reset_mid_round;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
